packed_lane_serializer: RTL and testbench



---
 rtl/packed_lane_serializer.sv | 152 +++++++++++++++
 tb/tb_packed_lane_serializer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/packed_lane_serializer.sv
// packed_lane_serializer
//
// Takes one packed frame of LANES x LANE_W bits through a valid/ready input
// handshake. It then sends the frame one lane per beat through a valid/ready
// output handshake. Lane [0] goes out first. Frames can follow each other with
// no bubble: a new frame is accepted on the handshake of the last beat.
//
// Parameters:
//   LANES       lanes per frame (>= 2)
//   LANE_W      bits per lane; bit [LANE_W-1] is even parity over [LANE_W-2:0]
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous active-high reset
//   in_valid    frame valid
//   in_ready    frame accepted when in_valid && in_ready (combinational from out_ready)
//   in_data     packed frame, lane [0] sent first
//   out_valid   lane beat valid
//   out_ready   downstream ready
//   out_data    current lane
//   out_index   lane number of the current beat
//   out_last    high on the beat whose index is LANES-1
//   busy        high while a frame is held
//   parity_err  sticky lane parity error
//
// Optional feature, macro PACKED_LANE_PARITY_CHECK_EN:
//   When defined, the parity bit of every lane that is handed off is checked.
//   A bad lane sets parity_err. parity_err stays set until the next frame is
//   accepted or until rst. When undefined, parity_err is tied to 0.

module packed_lane_serializer #(
  parameter int LANES  = 16,
  parameter int LANE_W = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][LANE_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANE_W-1:0]            out_data,
  output logic [$clog2(LANES)-1:0]     out_index,
  output logic                         out_last,
  output logic                         busy,
  output logic                         parity_err
);

  localparam int IDX_W = $clog2(LANES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  if (LANES < 2) begin : g_bad_lanes
    $error("packed_lane_serializer: LANES must be >= 2");
  end

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                       state;
  logic [LANES-1:0][LANE_W-1:0] frame;
  logic [IDX_W-1:0]             index;
  logic [IDX_W-1:0]             next_idx;

  // The next index is only used when index is below LAST_IDX. That means it
  // never goes past LANES-1, even when LANES is not a power of two.
  assign next_idx  = index + IDX_W'(1);
  assign out_index = index;

  // A new frame can be taken while idle, or on the handshake of the final
  // beat. The final-beat case is what keeps back-to-back frames bubble-free.
  // It is the only path from out_ready to in_ready.
  assign in_ready = (state == IDLE) ||
                    ((state == SEND) && (index == LAST_IDX) && out_ready);

  // Frame FSM. Every output is updated here so that each one comes straight
  // from a register. When the index moves, out_data is preloaded with the lane
  // for that new index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      index     <= '0;
      frame     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            frame     <= in_data;
            index     <= '0;
            out_data  <= in_data[0];
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (index != LAST_IDX) begin
              index    <= next_idx;
              out_data <= frame[next_idx];
              out_last <= (next_idx == LAST_IDX);
            end else if (in_valid) begin
              frame     <= in_data;
              index     <= '0;
              out_data  <= in_data[0];
              out_last  <= 1'b0;
            end else begin
              index     <= '0;
              out_last  <= 1'b0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PACKED_LANE_PARITY_CHECK_EN
  logic beat;
  logic accept;
  logic lane_bad;

  assign beat     = out_valid && out_ready;
  assign accept   = in_valid && in_ready;
  assign lane_bad = out_data[LANE_W-1] != (^out_data[LANE_W-2:0]);

  // Sticky parity flag. If a bad final lane hands off in the same cycle that
  // the next frame is accepted, setting the flag wins, so the error is not
  // lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (beat && lane_bad) begin
      parity_err <= 1'b1;
    end else if (accept) begin
      parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_packed_lane_serializer.sv
// tb_packed_lane_serializer
//
// Testbench for packed_lane_serializer with LANES=16 and LANE_W=9.
//
// Each accepted frame is added to a queue as 16 expected beats. The queue is
// the reference: out_valid/busy mean "queue not empty", and in_ready means
// "queue empty, or one beat left and it is being taken". A monitor on the
// falling edge compares the DUT against the front of the queue and pops it on
// every handshake. The parity flag is tracked from the lanes popped.
// Optional macro PACKED_LANE_PARITY_CHECK_EN enables the parity expectations.

module tb_packed_lane_serializer;

  localparam int LANES  = 16;
  localparam int LANE_W = 9;

  typedef logic [LANES-1:0][LANE_W-1:0] frame_t;

  typedef struct {
    logic [LANE_W-1:0] data;
    logic [3:0]        idx;
    logic              last;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  frame_t            drv_frame;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_data;
  logic [3:0]        out_index;
  logic              out_last;
  logic              busy;
  logic              parity_err;

  beat_t exp_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;
  int    beats = 0;
  int    cyc = 0;
  int    pat_cnt = 0;
  int    ready_mode = 0;
  logic  model_accept = 1'b0;
  logic  model_perr = 1'b0;
  logic  accepted = 1'b0;

  packed_lane_serializer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (drv_frame),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .busy       (busy),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [LANE_W-1:0] goodLane(input int v);
    logic [7:0] d;
    d = v[7:0];
    return {^d, d};
  endfunction

  // Reference monitor. It checks outputs against the queue, pops a beat on
  // each handshake, and predicts whether the upcoming edge accepts a frame.
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    logic bad;
    cyc++;
    exp_valid = exp_q.size() != 0;
    exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && out_ready);
    if (rst) begin
      exp_q.delete();
      model_perr   = 1'b0;
      model_accept = 1'b0;
    end else begin
      bad = 1'b0;
      checkOutput("out_valid", out_valid, exp_valid);
      checkOutput("in_ready", in_ready, exp_ready);
      checkOutput("busy", busy, exp_valid);
      checkOutput("parity_err", parity_err, model_perr);
      if (exp_valid) begin
        checkOutput("out_data", out_data, exp_q[0].data);
        checkOutput("out_index", out_index, exp_q[0].idx);
        checkOutput("out_last", out_last, exp_q[0].last);
        if (out_ready) begin
          bad = exp_q[0].data[LANE_W-1] != (^exp_q[0].data[LANE_W-2:0]);
          void'(exp_q.pop_front());
          beats++;
        end
      end
      model_accept = in_valid && exp_ready;
`ifdef PACKED_LANE_PARITY_CHECK_EN
      if (bad) model_perr = 1'b1;
      else if (model_accept) model_perr = 1'b0;
`endif
    end
  end

  // Advances one clock. An accepted frame is queued as expected beats, and
  // out_ready is driven for the next cycle.
  task automatic stepCycle();
    @(negedge clk);
    #2;
    accepted = 1'b0;
    if (model_accept) begin
      for (int i = 0; i < LANES; i++)
        exp_q.push_back('{data: drv_frame[i], idx: 4'(i), last: (i == LANES - 1)});
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((pat_cnt % 4) == 0) || ((pat_cnt % 4) == 3);
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    pat_cnt++;
  endtask

  task automatic applyStimulus(input frame_t f);
    int n;
    drv_frame = f;
    in_valid  = 1'b1;
    n = 0;
    do begin
      stepCycle();
      n++;
    end while (!accepted && n < 300);
    if (!accepted) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  task automatic waitBeats(input int target);
    int n;
    n = 0;
    while (beats < target && n < 500) begin
      stepCycle();
      n++;
    end
    checkOutput("beat_wait", (beats >= target), 1);
  endtask

  initial begin
    frame_t k_frame;
    frame_t f;
    int     b0;
    int     c0;

    for (int i = 0; i < LANES; i++) k_frame[i] = goodLane(i);

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    drv_frame = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_index", out_index, 0);
    checkOutput("reset_out_last", out_last, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_parity_err", parity_err, 0);
    @(posedge clk);
    #1;

    // Single frame, downstream always ready.
    ready_mode = 0;
    applyStimulus(k_frame);
    in_valid = 1'b0;
    drain();

    // Single frame under a 1,0,0,1 ready pattern.
    ready_mode = 1;
    pat_cnt = 0;
    applyStimulus(k_frame);
    in_valid = 1'b0;
    drain();

    // Two back-to-back frames: 32 beats in 32 cycles.
    ready_mode = 0;
    for (int i = 0; i < LANES; i++) f[i] = goodLane(i + 100);
    applyStimulus(f);
    b0 = beats;
    c0 = cyc;
    applyStimulus(k_frame);
    in_valid = 1'b0;
    drain();
    checkOutput("b2b_beats", beats - b0, 32);
    checkOutput("b2b_cycles", cyc - c0, 32);

    // Reset after the beat-5 handshake abandons the frame.
    b0 = beats;
    applyStimulus(k_frame);
    in_valid = 1'b0;
    waitBeats(b0 + 6);
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    for (int i = 0; i < LANES; i++) f[i] = goodLane(i + 200);
    applyStimulus(f);
    in_valid = 1'b0;
    drain();

    // Bad parity on lane 3, good lane 4, then a clean frame clears the flag.
    f = k_frame;
    f[3] = 9'h001;
    f[4] = 9'h101;
    applyStimulus(f);
    in_valid = 1'b0;
    drain();
    repeat (3) stepCycle();
    applyStimulus(k_frame);
    in_valid = 1'b0;
    drain();

    // in_valid pulse during beat 7 is ignored.
    b0 = beats;
    applyStimulus(k_frame);
    in_valid = 1'b0;
    waitBeats(b0 + 7);
    for (int i = 0; i < LANES; i++) drv_frame[i] = LANE_W'($urandom);
    in_valid = 1'b1;
    stepCycle();
    in_valid = 1'b0;
    drain();

    // Random frames, random ready, random gaps, random parity.
    ready_mode = 2;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < LANES; i++) f[i] = LANE_W'($urandom);
      applyStimulus(f);
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) stepCycle();
      end
    end
    in_valid = 1'b0;
    drain();
    repeat (2) stepCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
